// File: rtl/version_info_streamer.sv
// Round-robin arbiter that streams a 13-byte framed, XOR-checksummed build-version
// record to the granted requester over an AXI-Stream style master port.
module version_info_streamer #(
  parameter int unsigned N_REQ      = 2,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter logic [7:0]  VER_MAJOR  = 8'd0,
  parameter logic [7:0]  VER_MINOR  = 8'd0,
  parameter logic [7:0]  VER_PATCH  = 8'd0,
  parameter logic [7:0]  VER_BUILD  = 8'd0,
  parameter logic [15:0] VER_YEAR   = 16'h0000,
  parameter logic [7:0]  VER_MONTH  = 8'h00,
  parameter logic [7:0]  VER_DAY    = 8'h00,
  parameter logic [7:0]  VER_HOUR   = 8'h00,
  parameter logic [7:0]  VER_MINUTE = 8'h00,
  parameter logic [7:0]  VER_SECOND = 8'h00,
  localparam int unsigned TID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [TID_W-1:0] m_tid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       idx_q;
  logic [TID_W-1:0] ptr_q;
  logic [TID_W-1:0] tid_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             busy_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic [7:0]       tdata_q;
  logic [7:0]       csum_q;

  logic             win_found_s;
  logic [TID_W-1:0] win_idx_s;
  logic [TID_W-1:0] cand_s;

  // Payload byte for a frame position; the checksum slot is supplied by csum_q.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = VER_MAJOR;
      4'd2:    b = VER_MINOR;
      4'd3:    b = VER_PATCH;
      4'd4:    b = VER_BUILD;
      4'd5:    b = VER_YEAR[15:8];
      4'd6:    b = VER_YEAR[7:0];
      4'd7:    b = VER_MONTH;
      4'd8:    b = VER_DAY;
      4'd9:    b = VER_HOUR;
      4'd10:   b = VER_MINUTE;
      4'd11:   b = VER_SECOND;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Round-robin search starting at the pointer, wrapping around the requester set.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      cand_s = TID_W'((int'(ptr_q) + i) % int'(N_REQ));
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s;
      end else begin
        win_found_s = win_found_s;
        win_idx_s   = win_idx_s;
      end
    end
  end

  // Frame sequencer: grant, byte serialisation with running checksum, one-cycle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      ptr_q    <= '0;
      tid_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= 8'h00;
      csum_q   <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          if (win_found_s) begin
            state_q  <= S_SEND;
            gnt_q    <= N_REQ'(1'b1) << win_idx_s;
            tid_q    <= win_idx_s;
            busy_q   <= 1'b1;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tdata_q  <= frame_byte(4'd0);
            idx_q    <= 4'd0;
            csum_q   <= 8'h00;
          end
        end
        S_SEND: begin
          if (tvalid_q && m_tready) begin
            if (idx_q == 4'd12) begin
              state_q  <= S_GAP;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tdata_q  <= 8'h00;
              gnt_q    <= '0;
              done_q   <= gnt_q;
              ptr_q    <= (tid_q == TID_W'(N_REQ - 1)) ? '0 : tid_q + 1'b1;
            end else begin
              idx_q <= idx_q + 4'd1;
              if (idx_q != 4'd0) begin
                csum_q <= csum_step(csum_q, tdata_q);
              end
              // Byte 11 is leaving now, so fold it in on the fly to present the checksum.
              if (idx_q == 4'd11) begin
                tdata_q <= csum_step(csum_q, tdata_q);
                tlast_q <= 1'b1;
              end else begin
                tdata_q <= frame_byte(idx_q + 4'd1);
                tlast_q <= 1'b0;
              end
            end
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= '0;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          tvalid_q <= 1'b0;
          tlast_q  <= 1'b0;
          gnt_q    <= '0;
          done_q   <= '0;
        end
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign m_tdata  = tdata_q;
  assign m_tvalid = tvalid_q;
  assign m_tlast  = tlast_q;
  assign m_tid    = tid_q;

endmodule

// File: tb/tb_version_info_streamer.sv
// Scoreboard bench: a cycle-level reference model predicts grants and frame bytes,
// a negedge monitor pops and compares every handshake and the control outputs.
module tb_version_info_streamer;
  localparam int N = 2;
  localparam logic [7:0] FRAME [13] = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h48, 8'h20, 8'h26,
                                        8'h01, 8'h07, 8'h12, 8'h23, 8'h05, 8'h7C};

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [N-1:0] req = '0;
  logic         m_tready = 1'b0;
  logic [N-1:0] gnt, done;
  logic         busy, m_tvalid, m_tlast;
  logic [7:0]   m_tdata;
  logic [0:0]   m_tid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  version_info_streamer #(
    .N_REQ(N), .SYNC_BYTE(8'hA5),
    .VER_MAJOR(8'd1), .VER_MINOR(8'd2), .VER_PATCH(8'd3), .VER_BUILD(8'h48),
    .VER_YEAR(16'h2026), .VER_MONTH(8'h01), .VER_DAY(8'h07),
    .VER_HOUR(8'h12), .VER_MINUTE(8'h23), .VER_SECOND(8'h05)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .done(done), .busy(busy),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tid(m_tid)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         t;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rem = bytes still owed in the current frame, gap_f marks the
  // single post-frame busy cycle, wait_c blocks arbitration for the idle cycle after it.
  int rem = 0, wait_c = 0, mptr = 0, mtid = 0;
  bit gap_f = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    bit found;
    if (!rst_n) begin
      rem = 0; wait_c = 0; mptr = 0; mtid = 0; gap_f = 1'b0;
      exp_q.delete();
    end else begin
      gap_f = 1'b0;
      if (rem > 0) begin
        if (m_tready) begin
          rem--;
          if (rem == 0) begin
            gap_f  = 1'b1;
            wait_c = 1;
            mptr   = (mtid + 1) % N;
          end
        end
      end else if (wait_c > 0) begin
        wait_c--;
      end else if (req != '0) begin
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          int c;
          c = (mptr + i) % N;
          if (!found && req[c]) begin
            found = 1'b1;
            mtid  = c;
          end
        end
        rem = 13;
        for (int j = 0; j < 13; j++) begin
          e.d = FRAME[j];
          e.l = (j == 12);
          e.t = mtid;
          exp_q.push_back(e);
        end
      end
    end
  end

  // Monitor: per-cycle control checks, stall stability, and scoreboard pops on handshakes.
  logic       prev_ok = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [0:0] prev_tid = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    logic [N-1:0] oh;
    if (rst_n) begin
      oh = N'(1) << mtid;
      chk("tvalid", 32'(m_tvalid), 32'(rem > 0));
      chk("busy", 32'(busy), 32'((rem > 0) || gap_f));
      chk("gnt", 32'(gnt), (rem > 0) ? 32'(oh) : 32'd0);
      chk("done", 32'(done), gap_f ? 32'(oh) : 32'd0);
      if (prev_ok && prev_valid && !prev_ready) begin
        chk("stall_valid_held", 32'(m_tvalid), 32'd1);
        chk("stall_data_held", 32'(m_tdata), 32'(prev_data));
        chk("stall_last_held", 32'(m_tlast), 32'(prev_last));
        chk("stall_tid_held", 32'(m_tid), 32'(prev_tid));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %0h expected no handshake at %0t", m_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 32'(m_tdata), 32'(e.d));
          chk("tlast", 32'(m_tlast), 32'(e.l));
          chk("tid", 32'(m_tid), 32'(e.t));
        end
      end
    end
    prev_ok    = rst_n;
    prev_valid = m_tvalid;
    prev_ready = m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    prev_tid   = m_tid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_tid", 32'(m_tid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step(3);

    // Single request, sink always ready.
    m_tready = 1'b1; req = 2'b01; step(1); req = 2'b00; step(20);

    // Same frame under random back-pressure.
    req = 2'b01; step(1); req = 2'b00;
    for (int i = 0; i < 60; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      step(1);
    end
    m_tready = 1'b1; step(15);

    // Both requesters held: grants must alternate.
    req = 2'b11; step(60); req = 2'b00; step(20);

    // req[1] raised while req[0]'s frame is at byte 5.
    req = 2'b01; step(1); req = 2'b00; step(5); req = 2'b10; step(20); req = 2'b00; step(20);

    // Reset at byte 7: outputs must clear before the next clock edge.
    req = 2'b01; step(1); req = 2'b00; step(7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tvalid", 32'(m_tvalid), 32'd0);
    chk("async_gnt", 32'(gnt), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    req = 2'b10;
    step(2); rst_n = 1'b1; step(20); req = 2'b00; step(20);

    // Long stall on the sync byte.
    m_tready = 1'b0; req = 2'b01; step(1); req = 2'b00; step(20);
    m_tready = 1'b1; step(20);

    // Random requests and back-pressure.
    for (int i = 0; i < 300; i++) begin
      req      = N'($urandom_range(0, 3));
      m_tready = 1'($urandom_range(0, 1));
      step(1);
    end

    req = 2'b00; m_tready = 1'b1; step(40);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
